prbs_gen_multi: RTL
===================

Name: prbs_gen_multi

Overview:
- Runtime-selectable parallel PRBS pattern generator: PRBS7, PRBS15, PRBS23 or PRBS31, Fibonacci form, MSB-first, DATA_WIDTH bits per word.
- Adds over the fixed-polynomial generator:
  - valid/ready output handshake with a registered output word;
  - runtime mode and seed load;
  - single-bit error injection;
  - a transferred-word counter.
- Sits in front of serializers and BIST paths as the stimulus source for link and array test.

Parameters:
- DATA_WIDTH, 32: output word width, 1..64.
- DEFAULT_MODE, 3: mode after reset (0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31).
- CNT_WIDTH, 32: width of word_count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_load  in  1  pulse: load cfg_mode/cfg_seed
- cfg_mode  in  2  pattern select, sampled on cfg_load
- cfg_seed  in  31  seed, low W bits used (W = pattern length)
- inj_err  in  1  pulse: corrupt next produced word
- out_data  out  DATA_WIDTH  PRBS word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word
- mode  out  2  active pattern
- word_count  out  CNT_WIDTH  words transferred, wraps

Behaviour:
- Reset (rst high at clk edge):
  - state = all ones (31 bits); mode = DEFAULT_MODE.
  - out_valid = 0, out_data = 0, word_count = 0, inj pending flag = 0.
- First word:
  - Cycle after rst deasserts: out_valid = 1 with word 0 of the sequence.
  - Latency from reset release or load to valid is 1 cycle.
- Pattern table (W, tap t, output inverted?):
  - PRBS7: 7, 6, no
  - PRBS15: 15, 14, no
  - PRBS23: 23, 18, yes
  - PRBS31: 31, 28, yes
- Serial step (per generated bit):
  - fb = s[W-1] ^ s[t-1]; s <= {s[W-2:0], fb}; bits above W-1 are held at 0.
  - Emitted bit = fb, XOR 1 if the pattern is inverted.
- Word assembly:
  - One word = DATA_WIDTH consecutive steps, computed combinationally (unrolled).
  - First step lands in out_data[DATA_WIDTH-1], last step in bit 0.
  - State advances by DATA_WIDTH steps each time a word is produced.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - On transfer, the next word is loaded in the same edge; out_valid stays 1, giving full throughput.
  - With out_ready low, out_data and state are held stable.
  - out_valid never drops except on load or reset.
- Load (cfg_load high; priority over transfer):
  - mode <= cfg_mode; state <= cfg_seed masked to W bits.
  - A masked seed of zero is replaced by all ones in W bits.
  - out_valid <= 0 for exactly one cycle, then the first word of the new sequence.
  - A word transferred in the load cycle is counted; no word is produced from the old state.
  - A load while out_valid = 0 restarts the 1-cycle latency.
- Error injection:
  - inj_err sets the pending flag.
  - The next produced word has bit DATA_WIDTH-1 inverted; the flag clears at that edge.
  - Only the output word is corrupted, never the state, so the sequence continues undisturbed.
  - inj_err in the same cycle a word is produced corrupts that word.
  - Multiple pulses before production collapse into one.
  - The pending flag survives cfg_load and is cleared by rst.
- word_count: increments by 1 per transfer; wraps modulo 2^CNT_WIDTH.
- Reset mid-stream discards any held word immediately.

Decomposition:
- Package prbs_pkg holds:
  - mode encodings PRBS7..PRBS31;
  - per-mode width, tap and invert constants;
  - the all-ones seed constant.
- Sub-module prbs_word_step: purely combinational; inputs state and mode; outputs next state and raw word for DATA_WIDTH unrolled steps.
- Top holds the state register, output register, handshake, load and injection logic, and the counter.

Test Plan:
- DATA_WIDTH=8, reset, mode=0, out_ready=1 -> out_valid rises 1 cycle after reset release; words 8'h02, 8'h0C; word_count=2 after two transfers.
- Same configuration, out_ready low for 5 cycles after first valid -> out_data held at 8'h02, word_count=0; then releases with 8'h0C next.
- inj_err pulse before first transfer, mode 0 -> first word 8'h82, second 8'h0C, i.e. the sequence is uncorrupted.
- cfg_load with mode=0, seed=0 -> treated as 7'h7F; out_valid=0 for one cycle, then 8'h02.
- Mode 3, DATA_WIDTH=32, continuous ready, 2^31-1 words -> state returns to seed; every output word equals the reference software model, including inversion.
- rst asserted mid-stream with out_valid=1 and ready low -> next cycle out_valid=0, word_count=0, mode=DEFAULT_MODE, pending injection cleared.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the multi-pattern PRBS generator.
// Holds the mode encodings, the per-mode length/tap/invert table, the
// per-mode state masks and the all-ones seed constant.
package prbs_pkg;

    localparam int unsigned STATE_W = 31;
    localparam int unsigned MODE_W  = 2;

    typedef enum logic [MODE_W-1:0] {
        PRBS7  = 2'd0,
        PRBS15 = 2'd1,
        PRBS23 = 2'd2,
        PRBS31 = 2'd3
    } prbs_mode_e;

    // Per-mode pattern parameters: register length, feedback tap, output inversion
    typedef struct packed {
        logic [4:0] width;
        logic [4:0] tap;
        logic       inv;
    } prbs_cfg_t;

    localparam logic [STATE_W-1:0] SEED_ONES = '1;

    // Pattern table lookup
    function automatic prbs_cfg_t mode_cfg(input prbs_mode_e m);
        prbs_cfg_t c;
        case (m)
            PRBS7:   c = '{width: 5'd7,  tap: 5'd6,  inv: 1'b0};
            PRBS15:  c = '{width: 5'd15, tap: 5'd14, inv: 1'b0};
            PRBS23:  c = '{width: 5'd23, tap: 5'd18, inv: 1'b1};
            default: c = '{width: 5'd31, tap: 5'd28, inv: 1'b1};
        endcase
        return c;
    endfunction

    // All-ones mask covering the W live state bits of a mode
    function automatic logic [STATE_W-1:0] mode_mask(input prbs_mode_e m);
        logic [STATE_W-1:0] k;
        case (m)
            PRBS7:   k = 31'h0000_007F;
            PRBS15:  k = 31'h0000_7FFF;
            PRBS23:  k = 31'h007F_FFFF;
            default: k = SEED_ONES;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/prbs_word_step.sv
// Combinational DATA_WIDTH-step unrolled Fibonacci LFSR advance.
// Ports:
//   i_state  current 31-bit state (bits above W-1 ignored)
//   i_mode   active pattern
//   o_state  state after DATA_WIDTH serial steps
//   o_word   raw output word, first step in the MSB, inversion applied
module prbs_word_step
    import prbs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [STATE_W-1:0]    i_state,
    input  prbs_mode_e            i_mode,
    output logic [STATE_W-1:0]    o_state,
    output logic [DATA_WIDTH-1:0] o_word
);

    prbs_cfg_t          w_cfg;
    logic [STATE_W-1:0] w_mask;
    logic [STATE_W-1:0] w_s;
    logic               w_fb;

    // Unrolled serial steps; the mask keeps bits above W-1 at zero
    always_comb begin
        w_cfg  = mode_cfg(i_mode);
        w_mask = mode_mask(i_mode);
        w_s    = i_state & w_mask;
        w_fb   = 1'b0;
        o_word = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            w_fb = w_s[w_cfg.width - 5'd1] ^ w_s[w_cfg.tap - 5'd1];
            w_s  = ((w_s << 1) | STATE_W'(w_fb)) & w_mask;
            o_word[int'(DATA_WIDTH) - 1 - i] = w_fb ^ w_cfg.inv;
        end
        o_state = w_s;
    end

endmodule

// File: rtl/prbs_gen_multi.sv
// Runtime-selectable parallel PRBS generator (PRBS7/15/23/31) with a
// valid/ready output, seed/mode load, single-bit error injection and a
// transferred-word counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_load          pulse: load cfg_mode / cfg_seed (wins over transfer)
//   cfg_mode          pattern select
//   cfg_seed          seed, masked to the pattern length
//   inj_err           pulse: invert MSB of the next produced word
//   out_data/valid    registered output word and its valid
//   out_ready         consumer accept
//   mode              active pattern
//   word_count        transfers, wrapping
module prbs_gen_multi
    import prbs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEFAULT_MODE = 3,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_load,
    input  logic [MODE_W-1:0]     cfg_mode,
    input  logic [STATE_W-1:0]    cfg_seed,
    input  logic                  inj_err,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MODE_W-1:0]     mode,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam prbs_mode_e RST_MODE = prbs_mode_e'(MODE_W'(DEFAULT_MODE));

    logic [STATE_W-1:0]    r_state;
    prbs_mode_e            r_mode;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_inj_pend;
    logic [CNT_WIDTH-1:0]  r_count;

    logic [STATE_W-1:0]    w_next_state;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_xfer;
    logic                  w_produce;
    logic                  w_inj;
    prbs_mode_e            w_cfg_mode;
    logic [STATE_W-1:0]    w_cfg_mask;
    logic [STATE_W-1:0]    w_seed;
    logic [STATE_W-1:0]    w_seed_fix;
    logic [DATA_WIDTH-1:0] w_inj_mask;

    prbs_word_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .i_state (r_state),
        .i_mode  (r_mode),
        .o_state (w_next_state),
        .o_word  (w_word)
    );

    // Handshake and load qualification
    always_comb begin
        w_xfer     = r_valid & out_ready;
        w_produce  = ~cfg_load & (~r_valid | w_xfer);
        w_inj      = r_inj_pend | inj_err;
        w_inj_mask = DATA_WIDTH'(w_inj) << (DATA_WIDTH - 1);
        w_cfg_mode = prbs_mode_e'(cfg_mode);
        w_cfg_mask = mode_mask(w_cfg_mode);
        w_seed     = cfg_seed & w_cfg_mask;
        // An all-zero LFSR would lock up, so substitute all ones
        w_seed_fix = (w_seed == '0) ? w_cfg_mask : w_seed;
    end

    // State, output word, injection flag and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SEED_ONES;
            r_mode     <= RST_MODE;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_inj_pend <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_xfer) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
            if (cfg_load) begin
                r_mode     <= w_cfg_mode;
                r_state    <= w_seed_fix;
                r_valid    <= 1'b0;
                r_inj_pend <= w_inj;
            end else if (w_produce) begin
                // Corruption applies to the output word only, never the state
                r_state    <= w_next_state;
                r_data     <= w_word ^ w_inj_mask;
                r_valid    <= 1'b1;
                r_inj_pend <= 1'b0;
            end else begin
                r_inj_pend <= w_inj;
            end
        end
    end

    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign mode       = r_mode;
    assign word_count = r_count;

endmodule
